// File: rtl/ass_cpu.sv
// Two-channel CPU-side master that streams 16-bit words to two peripherals
// over independent four-phase req/ack handshakes with parity-tagged transfers.
module ass_cpu #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] DATA1_INIT  = 16'h0000,
  parameter logic [15:0] DATA2_INIT  = 16'h8000,
  parameter logic [15:0] DATA_STEP   = 16'h0001,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic        clkCPU,
  input  logic        rstCPU,
  input  logic [1:0]  inAck1,
  input  logic [1:0]  inAck2,
  output logic [1:0]  outSend1,
  output logic [1:0]  outSend2,
  output logic [15:0] outData1,
  output logic [15:0] outData2
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StRel} stateT;

  logic [1:0]  sendArr [2];
  logic [15:0] dataArr [2];

  assign outSend1 = sendArr[0];
  assign outSend2 = sendArr[1];
  assign outData1 = dataArr[0];
  assign outData2 = dataArr[1];

  for (genvar ch = 0; ch < 2; ch++) begin : genCh
    localparam logic [15:0] DataInit = (ch == 0) ? DATA1_INIT : DATA2_INIT;

    logic [1:0]                   ackIn;
    logic [SYNC_STAGES-1:0][1:0]  syncQ;
    logic [1:0]                   syncAck;
    stateT                        stateQ, stateD;
    logic [15:0]                  dataQ, dataD;
    logic                         parityQ, parityD;
    logic                         doneQ, doneD;
    logic [CntW-1:0]              cntQ, cntD;
    logic [1:0]                   sendQ, sendD;

    assign ackIn   = (ch == 0) ? inAck1 : inAck2;
    assign syncAck = syncQ[SYNC_STAGES-1];

    always_comb begin
      stateD  = stateQ;
      dataD   = dataQ;
      parityD = parityQ;
      doneD   = doneQ;
      cntD    = cntQ;
      unique case (stateQ)
        StIdle: stateD = StReq;
        StReq: begin
          // Only an ack echoing the current parity counts; anything else waits.
          if (syncAck == {parityQ, 1'b1}) begin
            stateD = StRel;
            doneD  = 1'b1;
            cntD   = '0;
          end else if (cntQ == CntMax) begin
            stateD = StRel;
            doneD  = 1'b0;
            cntD   = '0;
          end else begin
            cntD = cntQ + CntW'(1);
          end
        end
        StRel: begin
          if (!syncAck[0]) begin
            stateD = StIdle;
            if (doneQ) begin
              dataD   = dataQ + DATA_STEP;
              parityD = ~parityQ;
            end
          end
        end
        default: stateD = StIdle;
      endcase
      // Registered output built from next-state values, so it tracks the state.
      sendD = {parityD, stateD == StReq};
    end

    always_ff @(posedge clkCPU) begin
      if (!rstCPU) begin
        syncQ   <= '0;
        stateQ  <= StIdle;
        dataQ   <= DataInit;
        parityQ <= 1'b0;
        doneQ   <= 1'b0;
        cntQ    <= '0;
        sendQ   <= 2'b00;
      end else begin
        syncQ   <= {syncQ[SYNC_STAGES-2:0], ackIn};
        stateQ  <= stateD;
        dataQ   <= dataD;
        parityQ <= parityD;
        doneQ   <= doneD;
        cntQ    <= cntD;
        sendQ   <= sendD;
      end
    end

    assign sendArr[ch] = sendQ;
    assign dataArr[ch] = dataQ;
  end

endmodule

// File: tb/tb_ass_cpu.sv
// Self-checking bench for ass_cpu: asynchronous peripheral models, a stream
// model (word k = init + k, parity k%2), timeout/retry and reset scenarios.
module tb_ass_cpu;

  localparam logic [15:0] D1 = 16'h0000;
  localparam logic [15:0] D2 = 16'h8000;

  logic clkCPU, clkP1, clkP2;
  logic rstCPU, rstW;
  logic [1:0]  ack [2];
  logic [1:0]  outSend1, outSend2, wSend1, wSend2;
  logic [15:0] outData1, outData2, wData1, wData2;
  logic [1:0]  wAck1, wAck2;
  logic [1:0]  sendW [2];
  logic [15:0] dataW [2];

  int checks, failures;
  bit active [2];
  int okLeft [2];
  int dly;
  logic [16:0] rx1 [$];
  logic [16:0] rx2 [$];

  assign sendW[0] = outSend1;
  assign sendW[1] = outSend2;
  assign dataW[0] = outData1;
  assign dataW[1] = outData2;

  ass_cpu dut (
    .clkCPU(clkCPU), .rstCPU(rstCPU), .inAck1(ack[0]), .inAck2(ack[1]),
    .outSend1(outSend1), .outSend2(outSend2), .outData1(outData1), .outData2(outData2)
  );

  ass_cpu #(.DATA1_INIT(16'hFFFF)) wdut (
    .clkCPU(clkCPU), .rstCPU(rstW), .inAck1(wAck1), .inAck2(wAck2),
    .outSend1(wSend1), .outSend2(wSend2), .outData1(wData1), .outData2(wData2)
  );

  initial begin clkCPU = 0; forever #10 clkCPU = ~clkCPU; end
  initial begin clkP1 = 0; #3; forever begin clkP1 = 1; #17; clkP1 = 0; #17; end end
  initial begin clkP2 = 0; #1; forever begin clkP2 = 1; #8; clkP2 = 0; #8; end end

  // Peripheral: acks a request (echoing parity while okLeft > 0, inverted
  // echo otherwise), releases after req drops; random response delay.
  task automatic periph(input int ch);
    int waitCnt = 0;
    logic [1:0] s;
    ack[ch] = 2'b00;
    forever begin
      if (ch == 0) @(posedge clkP1); else @(posedge clkP2);
      s = sendW[ch];
      if (!active[ch]) begin
        ack[ch] = 2'b00;
      end else if (s[0] && (!ack[ch][0] || (ack[ch][1] != s[1] && okLeft[ch] > 0))) begin
        if (waitCnt > 0) waitCnt--;
        else begin
          if (okLeft[ch] > 0) begin
            ack[ch] = {s[1], 1'b1};
            okLeft[ch]--;
            if (ch == 0) rx1.push_back({s[1], dataW[ch]});
            else rx2.push_back({s[1], dataW[ch]});
          end else begin
            ack[ch] = {~s[1], 1'b1};
          end
          waitCnt = $urandom_range(0, dly);
        end
      end else if (!s[0] && ack[ch][0]) begin
        if (waitCnt > 0) waitCnt--;
        else begin
          ack[ch] = 2'b00;
          waitCnt = $urandom_range(0, dly);
        end
      end
    end
  endtask

  initial periph(0);
  initial periph(1);

  // Data and parity must hold while req stays high.
  initial begin
    logic        prevReq [2];
    logic [15:0] prevData [2];
    logic        prevPar [2];
    prevReq[0] = 0; prevReq[1] = 0;
    forever begin
      @(negedge clkCPU);
      for (int c = 0; c < 2; c++) begin
        if (prevReq[c] === 1'b1 && sendW[c][0] === 1'b1) begin
          checks++;
          if (dataW[c] !== prevData[c] || sendW[c][1] !== prevPar[c]) begin
            failures++;
            $display("FAIL stable_ch%0d: data=%h par=%b required data=%h par=%b", c + 1,
                     dataW[c], sendW[c][1], prevData[c], prevPar[c]);
          end
        end
        prevReq[c]  = sendW[c][0];
        prevData[c] = dataW[c];
        prevPar[c]  = sendW[c][1];
      end
    end
  end

  function automatic logic [1:0] curSend(input int sel);
    if (sel == 0) return outSend1;
    if (sel == 1) return outSend2;
    return wSend1;
  endfunction

  task automatic waitSend(input int sel, input logic [1:0] v, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clkCPU);
      if (curSend(sel) === v) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic doReset(input bit a1, input bit a2, input int ok1, input int ok2, input int d);
    active[0] = 0;
    active[1] = 0;
    @(negedge clkCPU);
    rstCPU = 0;
    repeat (5) @(negedge clkCPU);
    active[0] = a1; active[1] = a2;
    okLeft[0] = ok1; okLeft[1] = ok2;
    dly = d;
    rx1.delete();
    rx2.delete();
    rstCPU = 1;
  endtask

  task automatic test_reset;
    active[0] = 0; active[1] = 0;
    @(negedge clkCPU);
    rstCPU = 0;
    repeat (5) @(negedge clkCPU);
    checks += 4;
    if (outSend1 !== 2'b00) begin failures++; $display("FAIL rst_send1: got %b want 00", outSend1); end
    if (outSend2 !== 2'b00) begin failures++; $display("FAIL rst_send2: got %b want 00", outSend2); end
    if (outData1 !== D1) begin failures++; $display("FAIL rst_data1: got %h want %h", outData1, D1); end
    if (outData2 !== D2) begin failures++; $display("FAIL rst_data2: got %h want %h", outData2, D2); end
    rstCPU = 1;
    @(negedge clkCPU);
    checks += 2;
    if (outSend1 !== 2'b01) begin failures++; $display("FAIL rel_send1: got %b want 01", outSend1); end
    if (outSend2 !== 2'b01) begin failures++; $display("FAIL rel_send2: got %b want 01", outSend2); end
  endtask

  task automatic test_normal;
    bit ok;
    doReset(1, 0, 1000000, 0, 0);
    waitSend(0, 2'b01, 5, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL norm_req: got %b want 01", outSend1); end
    waitSend(0, 2'b00, 100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL norm_drop: got %b want 00", outSend1); end
    waitSend(0, 2'b11, 100, ok);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL norm_req2: got %b want 11", outSend1); end
    if (outData1 !== 16'h0001) begin failures++; $display("FAIL norm_data2: got %h want 0001", outData1); end
    waitSend(0, 2'b01, 100, ok);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL norm_req3: got %b want 01", outSend1); end
    if (outData1 !== 16'h0002) begin failures++; $display("FAIL norm_data3: got %h want 0002", outData1); end
  endtask

  task automatic test_async_stream;
    bit ok;
    logic [16:0] e;
    doReset(1, 1, 1000000, 1000000, 3);
    ok = 0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clkCPU);
      if (rx1.size() >= 50 && rx2.size() >= 50) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stream_count: got %0d/%0d want 50/50", rx1.size(), rx2.size());
    end else begin
      for (int k = 0; k < 50; k++) begin
        checks += 2;
        e = {k[0], D1 + 16'(k)};
        if (rx1[k] !== e) begin failures++; $display("FAIL stream1[%0d]: got %h want %h", k, rx1[k], e); end
        e = {k[0], D2 + 16'(k)};
        if (rx2[k] !== e) begin failures++; $display("FAIL stream2[%0d]: got %h want %h", k, rx2[k], e); end
      end
    end
  endtask

  task automatic test_wrong_parity;
    bit ok;
    doReset(0, 1, 0, 1, 0);
    waitSend(1, 2'b11, 200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL wp_req: got %b want 11", outSend2); end
    repeat (40) @(negedge clkCPU);
    checks += 2;
    if (outSend2 !== 2'b11) begin failures++; $display("FAIL wp_hold: got %b want 11", outSend2); end
    if (outData2 !== 16'h8001) begin failures++; $display("FAIL wp_data: got %h want 8001", outData2); end
    okLeft[1] = 1;
    waitSend(1, 2'b01, 200, ok);
    checks += 4;
    if (!ok) begin failures++; $display("FAIL wp_next: got %b want 01", outSend2); end
    if (outData2 !== 16'h8002) begin failures++; $display("FAIL wp_data2: got %h want 8002", outData2); end
    if (rx2.size() !== 2) begin failures++; $display("FAIL wp_rxn: got %0d want 2", rx2.size()); end
    else if (rx2[1] !== 17'h18001) begin failures++; $display("FAIL wp_rx: got %h want 18001", rx2[1]); end
  endtask

  task automatic test_timeout;
    bit ok;
    int n, g;
    logic [16:0] e;
    doReset(0, 1, 0, 1000000, 2);
    waitSend(0, 2'b01, 5, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL to_req: got %b want 01", outSend1); end
    for (int r = 0; r < 2; r++) begin
      n = 0;
      while (outSend1 === 2'b01 && n < 200) begin n++; @(negedge clkCPU); end
      g = 0;
      while (outSend1 === 2'b00 && g < 20) begin g++; @(negedge clkCPU); end
      checks += 4;
      if (n != 64) begin failures++; $display("FAIL to_len%0d: got %0d want 64", r, n); end
      if (g != 2) begin failures++; $display("FAIL to_gap%0d: got %0d want 2", r, g); end
      if (outSend1 !== 2'b01) begin failures++; $display("FAIL to_retry%0d: got %b want 01", r, outSend1); end
      if (outData1 !== D1) begin failures++; $display("FAIL to_data%0d: got %h want %h", r, outData1, D1); end
    end
    checks += 2;
    if (rx1.size() != 0) begin failures++; $display("FAIL to_rx1: got %0d want 0", rx1.size()); end
    if (rx2.size() < 5) begin failures++; $display("FAIL to_rx2n: got %0d want >=5", rx2.size()); end
    for (int k = 0; k < rx2.size(); k++) begin
      checks++;
      e = {k[0], D2 + 16'(k)};
      if (rx2[k] !== e) begin failures++; $display("FAIL to_rx2[%0d]: got %h want %h", k, rx2[k], e); end
    end
  endtask

  task automatic test_wrap_reset;
    bit ok;
    @(negedge clkCPU);
    rstW = 0; wAck1 = 2'b00; wAck2 = 2'b00;
    repeat (3) @(negedge clkCPU);
    checks += 2;
    if (wData1 !== 16'hFFFF) begin failures++; $display("FAIL wr_init: got %h want FFFF", wData1); end
    if (wSend1 !== 2'b00) begin failures++; $display("FAIL wr_send0: got %b want 00", wSend1); end
    rstW = 1;
    waitSend(2, 2'b01, 5, ok);
    wAck1 = 2'b01;
    waitSend(2, 2'b00, 20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL wr_drop: got %b want 00", wSend1); end
    wAck1 = 2'b00;
    waitSend(2, 2'b11, 20, ok);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL wr_req2: got %b want 11", wSend1); end
    if (wData1 !== 16'h0000) begin failures++; $display("FAIL wr_wrap: got %h want 0000", wData1); end
    rstW = 0;
    @(negedge clkCPU);
    checks += 3;
    if (wSend1 !== 2'b00) begin failures++; $display("FAIL wr_rsend: got %b want 00", wSend1); end
    if (wData1 !== 16'hFFFF) begin failures++; $display("FAIL wr_rdata1: got %h want FFFF", wData1); end
    if (wData2 !== 16'h8000) begin failures++; $display("FAIL wr_rdata2: got %h want 8000", wData2); end
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; failures = 0;
    rstCPU = 0; rstW = 0; wAck1 = 2'b00; wAck2 = 2'b00;
    dly = 0; okLeft[0] = 0; okLeft[1] = 0;
    test_reset();
    test_normal();
    test_async_stream();
    test_wrong_parity();
    test_timeout();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
